// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, LSB-first data, optional parity, 1-2 stop bits)
module uart_tx_frame #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_out,
  output logic              busy,
  output logic              tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter value");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic par, par_n, tick;
  always_comb begin
    tick = cnt == CW'(CLKS_PER_BIT - 1);
    state_n = state;
    sh_n = sh;
    par_n = par;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = START;
        sh_n = tx_data;
        par_n = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        sh_n = sh >> 1;
        if (bcnt == BW'(DATA_W - 1)) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick && bcnt == BW'(STOP_BITS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    bcnt_n = (state_n != state) ? '0 : tick ? bcnt + 1'b1 : bcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tx_out <= 1'b1;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      par <= par_n;
      tx_out <= (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : (state_n == PARITY) ? par_n : 1'b1;
      tx_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      tx_done <= state_n == STOP && bcnt_n == BW'(STOP_BITS - 1) && cnt_n == CW'(CLKS_PER_BIT - 1);
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed and random frames on four configurations checked against a bit-list model
module tb_uart_tx_frame;
  localparam int DW[4] = '{8, 8, 8, 5};
  localparam int CPB[4] = '{4, 4, 4, 2};
  localparam int PM[4] = '{0, 1, 2, 0};
  localparam int SB[4] = '{1, 1, 1, 2};
  logic clk, rst;
  logic [3:0] valid;
  logic [8:0] data [4];
  wire [3:0] ready, out, busy, done;
  int checks = 0;
  int failures = 0;
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_ready(ready[0]), .tx_data(data[0][7:0]),
    .tx_out(out[0]), .busy(busy[0]), .tx_done(done[0]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_ready(ready[1]), .tx_data(data[1][7:0]),
    .tx_out(out[1]), .busy(busy[1]), .tx_done(done[1]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_ready(ready[2]), .tx_data(data[2][7:0]),
    .tx_out(out[2]), .busy(busy[2]), .tx_done(done[2]));
  uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(2), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_ready(ready[3]), .tx_data(data[3][4:0]),
    .tx_out(out[3]), .busy(busy[3]), .tx_done(done[3]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input int i, input string tag);
    chk($sformatf("i%0d %s tx_out", i, tag), out[i], 1);
    chk($sformatf("i%0d %s busy", i, tag), busy[i], 0);
    chk($sformatf("i%0d %s tx_ready", i, tag), ready[i], 1);
    chk($sformatf("i%0d %s tx_done", i, tag), done[i], 0);
  endtask
  task automatic frame(input int i, input logic [8:0] d_in, input int abort_at, input bit hold, input bit disturb);
    int q[$];
    int w, f;
    logic [8:0] d;
    d = d_in & 9'((1 << DW[i]) - 1);
    w = 0;
    while (ready[i] !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    chk($sformatf("i%0d ready_wait", i), ready[i], 1);
    if (ready[i] !== 1'b1) return;
    valid[i] = 1'b1;
    data[i] = d;
    step();
    if (!hold) valid[i] = 1'b0;
    if (disturb) data[i] = 9'h1FF;
    q.push_back(0);
    for (int b = 0; b < DW[i]; b++) q.push_back(int'(d[b]));
    if (PM[i] != 0) q.push_back(($countones(d) % 2) ^ (PM[i] == 2 ? 1 : 0));
    for (int s = 0; s < SB[i]; s++) q.push_back(1);
    f = q.size() * CPB[i];
    for (int n = 1; n <= f; n++) begin
      if (disturb) valid[i] = (n % 3 == 0) && n < f;
      if (n == abort_at) begin
        valid[i] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_chk(i, "after_abort");
        for (int k = 0; k < 8; k++) begin
          step();
          chk($sformatf("i%0d abort_quiet_done k%0d", i, k), done[i], 0);
          chk($sformatf("i%0d abort_quiet_out k%0d", i, k), out[i], 1);
        end
        return;
      end
      chk($sformatf("i%0d d%0h n%0d tx_out", i, d, n), out[i], q[(n - 1) / CPB[i]]);
      chk($sformatf("i%0d n%0d busy", i, n), busy[i], 1);
      chk($sformatf("i%0d n%0d tx_ready", i, n), ready[i], 0);
      chk($sformatf("i%0d n%0d tx_done", i, n), done[i], (n == f) ? 1 : 0);
      step();
    end
    idle_chk(i, "end_frame");
  endtask
  initial begin
    int k;
    rst = 1'b1;
    valid = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle_chk(i, "reset");
    frame(0, 9'hA5, 0, 0, 0);
    frame(1, 9'hA5, 0, 0, 0);
    frame(1, 9'h01, 0, 0, 0);
    frame(2, 9'hA5, 0, 0, 0);
    frame(2, 9'h01, 0, 0, 0);
    frame(3, 9'h1F, 0, 0, 0);
    frame(0, 9'h3C, 0, 1, 0);
    frame(0, 9'hC3, 0, 0, 0);
    frame(1, 9'h00, 0, 0, 1);
    frame(0, 9'($urandom), 14, 0, 0);
    frame(0, 9'($urandom), 0, 0, 0);
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) begin
        k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) frame(i, 9'($urandom), 0, j < k - 1, 0);
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
